// File: rtl/lfsr_engine.sv
// lfsr_engine: WIDTH-bit LFSR with Fibonacci/Galois feedback, parallel seed
// load, external serial shift-in, all-zero lock-up detection with optional
// auto-recovery, and a step counter that flags return to the loaded start
// state.
//
// Control interface: there is no valid/ready handshake. A step happens on a
// rising clk edge where en=1 and load=0. A load happens on a rising clk edge
// where load=1, regardless of en. All outputs are registered.
module lfsr_engine #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] FTAPS        = 4'b1001,
  parameter logic [WIDTH-1:0] GTAPS        = 4'b0011,
  parameter logic [WIDTH-1:0] SEED         = 4'b0001,
  parameter bit               AUTO_RECOVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  input  logic             ext_sel,
  input  logic             ext_in,
  output logic [WIDTH-1:0] q,
  output logic             out_bit,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] step_cnt
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             lockup_q, lockup_d;
  logic             period_done_q, period_done_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;

  // Candidate next states for each step flavour.
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] ext_next;
  logic [WIDTH-1:0] step_next;
  logic             zero_lock;

  // Compute the three step candidates from the current state.
  always_comb begin
    fib_next = {q_q[WIDTH-2:0], ^(q_q & FTAPS)};
    gal_next = {q_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q_q[WIDTH-1]}} & GTAPS);
    ext_next = {q_q[WIDTH-2:0], ext_in};
  end

  // Select the next state and update flags and the step counter.
  always_comb begin
    q_d           = q_q;
    start_d       = start_q;
    lockup_d      = lockup_q;
    period_done_d = 1'b0;
    step_cnt_d    = step_cnt_q;
    step_next     = q_q;
    // Lock-up only matters for feedback steps; ext shifting can leave zero.
    zero_lock     = !ext_sel && (q_q == '0);

    if (ext_sel) begin
      step_next = ext_next;
    end else if (zero_lock) begin
      step_next = AUTO_RECOVER ? SEED : '0;
    end else if (mode) begin
      step_next = gal_next;
    end else begin
      step_next = fib_next;
    end

    if (load) begin
      q_d        = seed_in;
      start_d    = seed_in;
      step_cnt_d = '0;
      lockup_d   = 1'b0;
    end else if (en) begin
      q_d = step_next;
      if (zero_lock) begin
        lockup_d = 1'b1;
      end
      if (step_next == start_q) begin
        period_done_d = 1'b1;
        step_cnt_d    = '0;
      end else if (zero_lock && AUTO_RECOVER) begin
        step_cnt_d = '0;
      end else if (step_cnt_q != {WIDTH{1'b1}}) begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  // State registers, cleared to the seed state asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q           <= SEED;
      start_q       <= SEED;
      lockup_q      <= 1'b0;
      period_done_q <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      q_q           <= q_d;
      start_q       <= start_d;
      lockup_q      <= lockup_d;
      period_done_q <= period_done_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  assign q           = q_q;
  assign out_bit     = q_q[WIDTH-1];
  assign lockup      = lockup_q;
  assign period_done = period_done_q;
  assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Testbench for lfsr_engine: two instances (auto-recover on/off) share the
// same stimulus; each is checked every cycle against a reference model built
// from the arithmetic description of the sequences, plus directed literal
// sequences.
module tb_lfsr_engine;

  localparam int W        = 4;
  localparam int FTAPS_I  = 9;   // 4'b1001
  localparam int GTAPS_I  = 3;   // 4'b0011
  localparam int SEED_I   = 1;   // 4'b0001
  localparam int MAXCNT   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed_in = '0;
  logic         mode = 1'b0;
  logic         ext_sel = 1'b0;
  logic         ext_in = 1'b0;

  logic [W-1:0] q0, q1, cnt0, cnt1;
  logic         ob0, ob1, lk0, lk1, pd0, pd1;

  lfsr_engine #(.WIDTH(W), .FTAPS(4'b1001), .GTAPS(4'b0011), .SEED(4'b0001),
                .AUTO_RECOVER(1'b1)) u_dut_ar (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
    .mode(mode), .ext_sel(ext_sel), .ext_in(ext_in),
    .q(q0), .out_bit(ob0), .lockup(lk0), .period_done(pd0), .step_cnt(cnt0));

  lfsr_engine #(.WIDTH(W), .FTAPS(4'b1001), .GTAPS(4'b0011), .SEED(4'b0001),
                .AUTO_RECOVER(1'b0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
    .mode(mode), .ext_sel(ext_sel), .ext_in(ext_in),
    .q(q1), .out_bit(ob1), .lockup(lk1), .period_done(pd1), .step_cnt(cnt1));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0: auto-recover instance, index 1: hold-on-lockup instance.
  int m_q[2], m_start[2], m_cnt[2];
  bit m_lock[2], m_pd[2];

  function automatic int ref_next(int cur, bit md, bit es, bit ei, bit ar);
    int sh;
    sh = (cur * 2) % 16;
    if (es) return sh + (ei ? 1 : 0);
    if (cur == 0) return ar ? SEED_I : 0;
    if (!md) return sh + ($countones(cur & FTAPS_I) % 2);
    // Galois: multiply by x modulo the polynomial
    if (cur >= 8) return sh ^ GTAPS_I;
    return sh;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = SEED_I; m_start[i] = SEED_I; m_cnt[i] = 0;
      m_lock[i] = 1'b0; m_pd[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    int nxt;
    bit lockstep;
    for (int i = 0; i < 2; i++) begin
      if (load) begin
        m_q[i] = seed_in; m_start[i] = seed_in; m_cnt[i] = 0;
        m_lock[i] = 1'b0; m_pd[i] = 1'b0;
      end else if (en) begin
        nxt = ref_next(m_q[i], mode, ext_sel, ext_in, (i == 0));
        lockstep = !ext_sel && (m_q[i] == 0);
        if (lockstep) m_lock[i] = 1'b1;
        m_pd[i] = (nxt == m_start[i]);
        if (m_pd[i] || (lockstep && i == 0)) m_cnt[i] = 0;
        else if (m_cnt[i] < MAXCNT) m_cnt[i] = m_cnt[i] + 1;
        m_q[i] = nxt;
      end else begin
        m_pd[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("ar_q",      q0,   m_q[0]);
    check("ar_outbit", ob0,  (m_q[0] >= 8) ? 1 : 0);
    check("ar_lockup", lk0,  m_lock[0]);
    check("ar_pdone",  pd0,  m_pd[0]);
    check("ar_cnt",    cnt0, m_cnt[0]);
    check("nr_q",      q1,   m_q[1]);
    check("nr_outbit", ob1,  (m_q[1] >= 8) ? 1 : 0);
    check("nr_lockup", lk1,  m_lock[1]);
    check("nr_pdone",  pd1,  m_pd[1]);
    check("nr_cnt",    cnt1, m_cnt[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ld, input int sd, input bit e, input bit md,
                       input bit es, input bit ei);
    @(negedge clk);
    load = ld; seed_in = sd[W-1:0]; en = e; mode = md; ext_sel = es; ext_in = ei;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_q_async",    q0,  SEED_I);
    check("rst_lk_async",   lk0, 0);
    check("rst_pd_async",   pd0, 0);
    check("rst_cnt_async",  cnt0, 0);
    check("rst_q1_async",   q1,  SEED_I);
    @(negedge clk);
    load = 1'b0; en = 1'b0; ext_sel = 1'b0; mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int fib_exp[15] = '{3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8, 1};
  int gal_exp[15] = '{2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9, 1};
  int ext_pat[4]  = '{1, 0, 1, 1};

  initial begin
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;
    check_all();

    // Fibonacci full period from reset
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 1, 0, 0, 0);
      check("fib_seq", q0, fib_exp[k]);
      check("fib_pd", pd0, (k == 14) ? 1 : 0);
    end
    check("fib_cnt_wrap", cnt0, 0);

    // Galois full period from reset, with a few mid-sequence steps first
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 1, 1, 0, 0);
      check("gal_seq", q0, gal_exp[k]);
      check("gal_pd", pd0, (k == 14) ? 1 : 0);
    end

    // Lock-up from a zero load
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("lock_ar_q", q0, 1);
    check("lock_ar_flag", lk0, 1);
    check("lock_ar_cnt", cnt0, 0);
    check("lock_nr_q", q1, 0);
    check("lock_nr_flag", lk1, 1);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 6, 0, 0, 0, 0);
    check("lock_clear", lk0, 0);
    check("lock_clear_nr", lk1, 0);

    // External shift-in from zero
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, k % 2, 1, ext_pat[k][0]);
    check("ext_q", q0, 11);
    check("ext_lock", lk0, 0);

    // load wins over en, then one Fibonacci step
    drive(1, 10, 1, 0, 0, 0);
    check("ld_en_q", q0, 10);
    check("ld_en_cnt", cnt0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("ld_step_q", q0, 5);

    // Counter saturation: shift zeros in after loading 1111
    drive(1, 15, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 0, 1, 0, 1, 0);
    check("cnt_sat", cnt0, MAXCNT);

    // Reset mid-sequence, then hold with en=0
    drive(0, 0, 1, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 3; k++) drive(0, 0, 0, k % 2, 0, 0);
    check("hold_q", q0, SEED_I);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
